alu_result_misr: RTL and testbench

ALU_RESULT_MISR -- requirements
Module: alu_result_misr

---
 rtl/alu_result_misr.sv | 122 ++++++++++++
 tb/tb_alu_result_misr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_misr.sv
// ALU result compactor: results go through a small FIFO into a 32-bit MISR. At the end of a run the MISR is compared with EXP_SIG.
// Optional build macro ALU_MISR_ZERO_CNT_EN adds a saturating count of absorbed zero words.
`timescale 1ns/1ps
module alu_result_misr #(
  parameter int          DEPTH       = 4,
  parameter int          NUM_SAMPLES = 1024,
  parameter logic [31:0] EXP_SIG     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [15:0] sample_cnt,
`ifdef ALU_MISR_ZERO_CNT_EN
  output logic [15:0] zero_cnt,
`endif
  output logic [1:0]  fsm_state
);

  // Handshake: a word moves when in_valid && in_ready at a rising edge. in_ready
  // depends only on registered state, never on in_valid, and a producer may
  // hold in_valid/in_data until the transfer happens.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int          PW     = $clog2(DEPTH);
  localparam logic [PW:0] FULL_N = (PW + 1)'(DEPTH);
  localparam logic [15:0] NS     = 16'(NUM_SAMPLES);

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   occ;
  logic [15:0]   acc_cnt;
  logic [31:0]   sig;
  logic [31:0]   head;
  logic [31:0]   sig_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          restart;

  assign fifo_full  = (occ == FULL_N);
  assign fifo_empty = (occ == '0);
  assign in_ready   = (state == S_RUN) && !fifo_full && (acc_cnt < NS);
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_RUN) && !fifo_empty && (sample_cnt < NS);
  assign restart    = start && ((state == S_IDLE) || (state == S_DONE));

  assign head     = mem[rd_ptr];
  assign sig_next = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ head;

  assign busy      = (state == S_RUN) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign signature = sig;
  assign fsm_state = state;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state      <= rst ? S_IDLE : S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      acc_cnt    <= '0;
      sig        <= 32'hFFFF_FFFF;
      sample_cnt <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (sample_cnt == NS) state <= S_CHECK;
          if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            acc_cnt <= acc_cnt + 16'd1;
          end
          if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            sig        <= sig_next;
            sample_cnt <= sample_cnt + 16'd1;
          end
          case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
          endcase
        end
        S_CHECK: begin
          pass  <= (sig == EXP_SIG);
          state <= S_DONE;
        end
        default: state <= state;
      endcase
    end
  end

`ifdef ALU_MISR_ZERO_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      zero_cnt <= '0;
    end else if (pop && (head == 32'h0) && (zero_cnt != 16'hFFFF)) begin
      zero_cnt <= zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_misr.sv
// Randomized self-checking bench for alu_result_misr: three instances, each with a different DEPTH/NUM_SAMPLES/EXP_SIG.
// The reference model folds the accepted-word queue into a signature.
`timescale 1ns/1ps
module tb_alu_result_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  pass;
  logic [31:0] in_data    [3];
  logic [31:0] signature  [3];
  logic [15:0] sample_cnt [3];
  logic [1:0]  fsm_state  [3];
`ifdef ALU_MISR_ZERO_CNT_EN
  logic [15:0] zero_cnt   [3];
`endif

  logic [31:0] exp_q [$];
  logic [31:0] src_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  alu_result_misr #(.DEPTH(4), .NUM_SAMPLES(1), .EXP_SIG(32'hFFFF_FFFE)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(signature[0]), .sample_cnt(sample_cnt[0]),
`ifdef ALU_MISR_ZERO_CNT_EN
    .zero_cnt(zero_cnt[0]),
`endif
    .fsm_state(fsm_state[0]));

  alu_result_misr #(.DEPTH(4), .NUM_SAMPLES(8), .EXP_SIG(32'h0)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(signature[1]), .sample_cnt(sample_cnt[1]),
`ifdef ALU_MISR_ZERO_CNT_EN
    .zero_cnt(zero_cnt[1]),
`endif
    .fsm_state(fsm_state[1]));

  alu_result_misr #(.DEPTH(2), .NUM_SAMPLES(4), .EXP_SIG(32'h0)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .signature(signature[2]), .sample_cnt(sample_cnt[2]),
`ifdef ALU_MISR_ZERO_CNT_EN
    .zero_cnt(zero_cnt[2]),
`endif
    .fsm_state(fsm_state[2]));

  function automatic logic [31:0] exp_sig_of(input int k);
    return (k == 0) ? 32'hFFFF_FFFE : 32'h0;
  endfunction

  // Reference signature: start at all-ones, then for each word shift left and feed back the XOR of taps 31, 21, 1 and 0, then XOR in the word.
  function automatic logic [31:0] model_sig();
    logic [31:0] s;
    logic        fb;
    s = 32'hFFFF_FFFF;
    foreach (exp_q[i]) begin
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      s  = ((s << 1) | {31'd0, fb}) ^ exp_q[i];
    end
    return s;
  endfunction

  function automatic int model_zeros();
    int z = 0;
    foreach (exp_q[i]) if (exp_q[i] == 32'h0) z++;
    return z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic do_start(input int k);
    exp_q.delete();
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic fill_random(input int n, input int zero_pct);
    src_q.delete();
    for (int i = 0; i < n; i++)
      src_q.push_back(($urandom_range(0, 99) < zero_pct) ? 32'h0 : $urandom());
  endtask

  // Offers the words in src_q in order, optionally with idle gaps, and records each accepted word in exp_q.
  task automatic feed(input int k, input bit gaps);
    int budget = 400;
    bit acc;
    while (src_q.size() > 0 && budget > 0) begin
      in_valid[k] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data[k]  = src_q[0];
      acc = in_valid[k] && in_ready[k];
      tick();
      if (acc) exp_q.push_back(src_q.pop_front());
      budget--;
    end
    in_valid[k] = 1'b0;
    if (src_q.size() > 0) check("feed_timeout", 32'(src_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int k);
    int b = 0;
    while (!done[k] && b < 60) begin
      tick();
      b++;
    end
    check("done_timeout", {31'd0, done[k]}, 32'd1);
  endtask

  task automatic check_result(input int k, input string tag);
    logic [31:0] m;
    m = model_sig();
    check({tag, "_sig"}, signature[k], m);
    check({tag, "_cnt"}, {16'd0, sample_cnt[k]}, 32'(exp_q.size()));
    check({tag, "_pass"}, {31'd0, pass[k]}, {31'd0, (m == exp_sig_of(k))});
    check({tag, "_idle_io"}, {30'd0, busy[k], in_ready[k]}, 32'd0);
`ifdef ALU_MISR_ZERO_CNT_EN
    check({tag, "_zero_cnt"}, {16'd0, zero_cnt[k]}, 32'(model_zeros()));
`endif
  endtask

  initial begin
    logic [31:0] held_sig;
    rst      = 1'b1;
    start    = '0;
    in_valid = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_sig", signature[k], 32'hFFFF_FFFF);
      check("rst_cnt", {16'd0, sample_cnt[k]}, 32'd0);
      check("rst_flags", {28'd0, busy[k], done[k], pass[k], in_ready[k]}, 32'd0);
    end
    rst = 1'b0;

    // Words offered in IDLE are refused.
    in_valid = 3'b111;
    repeat (3) tick();
    check("idle_ready", {29'd0, in_ready}, 32'd0);
    check("idle_cnt", {16'd0, sample_cnt[1]}, 32'd0);
    in_valid = '0;

    // Single-sample runs: zero gives the expected signature, one does not.
    do_start(0);
    check("a_ready", {31'd0, in_ready[0]}, 32'd1);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h0;
    tick();
    in_valid[0] = 1'b0;
    tick();
    check("a0_sig_n1", signature[0], 32'hFFFF_FFFE);
    check("a0_cnt_n1", {16'd0, sample_cnt[0]}, 32'd1);
    tick();
    check("a0_check", {30'd0, busy[0], done[0]}, 32'd2);
    tick();
    check("a0_done_pass", {30'd0, done[0], pass[0]}, 32'd3);

    do_start(0);
    check("a1_restart", {28'd0, busy[0], done[0], pass[0], in_ready[0]}, 32'b1001);
    check("a1_restart_sig", signature[0], 32'hFFFF_FFFF);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h1;
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    check("a1_sig", signature[0], 32'hFFFF_FFFF);
    check("a1_done_pass", {30'd0, done[0], pass[0]}, 32'd2);

    // in_valid held high for the whole run: one absorb per cycle, then refusal.
    do_start(1);
    in_valid[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_data[1] = $urandom();
      check("b_ready_run", {31'd0, in_ready[1]}, 32'd1);
      exp_q.push_back(in_data[1]);
      tick();
      check("b_cnt_step", {16'd0, sample_cnt[1]}, 32'(j));
    end
    in_data[1] = $urandom();
    tick();
    check("b_cnt_full", {16'd0, sample_cnt[1]}, 32'd8);
    check("b_ready_after", {30'd0, in_ready[1], busy[1]}, 32'd1);
    tick();
    check("b_check", {29'd0, in_ready[1], busy[1], done[1]}, 32'd2);
    tick();
    check_result(1, "b_held");
    held_sig = signature[1];
    repeat (3) tick();
    check("done_frozen_sig", signature[1], held_sig);
    check("done_frozen_cnt", {16'd0, sample_cnt[1]}, 32'd8);
    check("done_ready", {31'd0, in_ready[1]}, 32'd0);
    in_valid[1] = 1'b0;

    // Reset in mid-run, asserted together with start, abandons the run.
    do_start(1);
    fill_random(3, 0);
    feed(1, 1'b0);
    rst      = 1'b1;
    start[1] = 1'b1;
    tick();
    rst      = 1'b0;
    start[1] = 1'b0;
    check("mid_rst_state", {30'd0, busy[1], done[1]}, 32'd0);
    check("mid_rst_sig", signature[1], 32'hFFFF_FFFF);
    check("mid_rst_cnt", {16'd0, sample_cnt[1]}, 32'd0);
    do_start(1);
    fill_random(8, 10);
    feed(1, 1'b1);
    wait_done(1);
    check_result(1, "b_after_rst");

    for (int r = 0; r < 6; r++) begin
      do_start(2);
      fill_random(4, 30);
      feed(2, 1'b1);
      wait_done(2);
      check_result(2, "c_rand");
    end
    for (int r = 0; r < 3; r++) begin
      do_start(1);
      fill_random(8, 20);
      feed(1, 1'b1);
      wait_done(1);
      check_result(1, "b_rand");
    end

    do_start(2);
    src_q = '{32'h0, 32'h5, 32'h0, 32'h0};
    feed(2, 1'b0);
    wait_done(2);
    check_result(2, "c_zeros");
`ifdef ALU_MISR_ZERO_CNT_EN
    check("zero_cnt_3", {16'd0, zero_cnt[2]}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
